// File: rtl/seq_booth_mac_if.sv
// Operand/result handshake bundle for seq_booth_mac.
//   master: operand source and result sink (drives in_valid, a, b, signed_mode,
//           acc_en, acc_clr, out_ready).
//   slave : multiplier core (drives in_ready, out_valid, y, acc).
interface seq_booth_mac_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 acc_en;
  logic                 acc_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;
  logic [ACC_W-1:0]     acc;

  modport master (
    output in_valid, a, b, signed_mode, acc_en, acc_clr, out_ready,
    input  in_ready, out_valid, y, acc
  );

  modport slave (
    input  in_valid, a, b, signed_mode, acc_en, acc_clr, out_ready,
    output in_ready, out_valid, y, acc
  );
endinterface

// File: rtl/seq_booth_mac.sv
// Iterative shift-add multiplier with running accumulator.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - seq_booth_mac_if.slave: operand handshake (in_valid/in_ready,
//            a, b, signed_mode, acc_en), result handshake (out_valid/out_ready,
//            y), acc_clr and the signed accumulator acc.
// Operands are reduced to magnitudes, multiplied unsigned over WIDTH steps,
// and the sign is reapplied when y is loaded.
module seq_booth_mac #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2*WIDTH+4
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_booth_mac_if.slave    bus
);

  localparam int CW = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state, state_nx;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mult;
  logic [2*WIDTH-1:0]   prod;
  logic [CW-1:0]        cnt;
  logic                 neg;
  logic                 sm_l;
  logic                 ae_l;
  logic [2*WIDTH-1:0]   y_r;
  logic [ACC_W-1:0]     acc_r;

  logic                 start;
  logic                 hs_out;
  logic                 last;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [ACC_W-1:0]     y_ext;

  assign start  = bus.in_valid && bus.in_ready;
  assign hs_out = bus.out_valid && bus.out_ready;
  // BUSY spends WIDTH cycles on shift-add steps and one more loading y.
  assign last   = (cnt == CW'(WIDTH));

  // -2^(WIDTH-1) negates to itself, which read unsigned is the right magnitude.
  assign a_mag = (bus.signed_mode && bus.a[WIDTH-1]) ? WIDTH'(-bus.a) : bus.a;
  assign b_mag = (bus.signed_mode && bus.b[WIDTH-1]) ? WIDTH'(-bus.b) : bus.b;

  assign y_ext = sm_l ? ACC_W'($signed(y_r)) : ACC_W'(y_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start)         state_nx = BUSY;
      BUSY: if (last)          state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // in_ready is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    bus.in_ready  = (state == IDLE) && rst_n;
    bus.out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      mult  <= '0;
      prod  <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      sm_l  <= 1'b0;
      ae_l  <= 1'b0;
      y_r   <= '0;
    end else if (start) begin
      mcand <= {{WIDTH{1'b0}}, a_mag};
      mult  <= b_mag;
      prod  <= '0;
      cnt   <= '0;
      neg   <= bus.signed_mode && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      sm_l  <= bus.signed_mode;
      ae_l  <= bus.acc_en;
    end else if (state == BUSY) begin
      if (last) begin
        y_r <= neg ? -prod : prod;
      end else begin
        if (mult[0]) prod <= prod + mcand;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        cnt   <= cnt + 1'b1;
      end
    end
  end

  // Clear takes priority, but a coincident accumulate still lands on the cleared value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (bus.acc_clr) begin
      acc_r <= (hs_out && ae_l) ? y_ext : '0;
    end else if (hs_out && ae_l) begin
      acc_r <= acc_r + y_ext;
    end
  end

  assign bus.y   = y_r;
  assign bus.acc = acc_r;

endmodule
